// File: rtl/shift_add_multiplier_pkg.sv
// shift_add_multiplier_pkg: shared state encoding and sizing constants
package shift_add_multiplier_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/shift_add_multiplier_add_rc.sv
// add_rc: combinational ripple-carry adder built from full-adder cells
module add_rc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[WIDTH];
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier with start/done handshake
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] mcand, sum;
  logic [WIDTH:0] upper;
  logic [CW-1:0] count;
  logic cout, last;
  add_rc #(.WIDTH(WIDTH)) u_add (
    .a   (acc[2*WIDTH-1:WIDTH]),
    .b   (mcand),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );
  always_comb begin
    last    = count == CW'(WIDTH - 1);
    upper   = acc[0] ? {cout, sum} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    acc_n   = {upper, acc[WIDTH-1:1]};
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
    busy    = state != IDLE;
    done    = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        mcand <= a;
        acc   <= {{WIDTH{1'b0}}, b};
        count <= '0;
      end else if (state == RUN) begin
        acc   <= acc_n;
        count <= count + 1'b1;
        if (last) product <= acc_n;
      end
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: scoreboard bench with a cycle-level handshake model
module tb_shift_add_multiplier;
  localparam int W = 4;
  logic clk = 0, rst = 1, start = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done;
  logic [2*W-1:0] product;
  int checks = 0, failures = 0, ndone = 0;
  logic [2*W-1:0] q[$];
  logic [1:0] m_st = 0;
  int m_cnt = 0;
  logic [2*W-1:0] m_exp = '0, m_prod = '0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x; b = y; start = 1;
    tick(1);
    start = 0;
    tick(6);
  endtask

  // Reference: handshake timing from the behavioural description, result from a*b
  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0; m_cnt <= 0; m_prod <= '0;
      q.delete();
    end else case (m_st)
      0: if (start) begin
        m_st <= 1; m_cnt <= 0;
        m_exp <= {4'b0, a} * {4'b0, b};
        q.push_back({4'b0, a} * {4'b0, b});
      end
      1: begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == W - 1) begin m_st <= 2; m_prod <= m_exp; end
      end
      default: m_st <= 0;
    endcase
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_st != 0));
    check("done", 32'(done), 32'(m_st == 2));
    check("product_hold", 32'(product), 32'(m_prod));
    if (done) begin
      ndone++;
      check("sb_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) check("sb_product", 32'(product), 32'(q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check("reset_product", 32'(product), 0);
    rst = 0;
    op(13, 11);
    check("p_13x11", 32'(product), 143);
    op(15, 15);
    check("p_15x15", 32'(product), 225);
    op(0, 9);
    check("p_0x9", 32'(product), 0);
    op(9, 0);
    check("p_9x0", 32'(product), 0);
    a = 6; b = 7; start = 1;
    tick(1);
    start = 0;
    tick(1);
    a = 2; b = 2; start = 1;
    tick(1);
    start = 0; a = 9; b = 9;
    tick(5);
    check("p_6x7_ignore", 32'(product), 42);
    a = 12; b = 5; start = 1;
    tick(1);
    start = 0;
    tick(2);
    rst = 1;
    tick(1);
    rst = 0;
    check("rst_busy", 32'(busy), 0);
    check("rst_product", 32'(product), 0);
    op(3, 5);
    check("p_3x5", 32'(product), 15);
    start = 1;
    for (int i = 0; i < 4; i++) begin
      a = W'(i + 5); b = W'(15 - i);
      tick(6);
    end
    for (int i = 0; i < 256; i++) begin
      a = W'(i >> 4); b = W'(i);
      tick(6);
    end
    start = 0;
    tick(8);
    check("done_count", 32'(ndone), 266);
    check("sb_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned WIDTH x WIDTH shift-and-add multiplier. It consumes a WIDTH-bit ripple-carry adder as its per-cycle partial-product adder.
- It sits directly downstream of the team's ripple adder. It supplies that adder's operands each cycle and consumes its sum/carry outputs.
- A start/done handshake makes it usable from a simple controller.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured on an accepted start.
- b  input  WIDTH  multiplier; captured on an accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  result register; held until the next result is written.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); it is sampled only on the rising clk edge.
- Reset values: state=IDLE, busy=0, done=0, product=0, internal acc/mcand/count=0.
- FSM states:
  - IDLE: if start=1 at an edge, capture mcand<=a, acc<={WIDTH zeros, b}, count<=0, go RUN. Otherwise stay in IDLE.
  - RUN: one iteration per edge, as follows.
    - Adder inputs are acc[2W-1:W] and mcand, with cin=0.
    - If acc[0]=1, upper <= {cout, sum}; otherwise upper <= {0, acc[2W-1:W]}.
    - acc <= {upper, acc[W-1:1]} (logical right shift by 1 including the carry).
    - count increments. On the edge where count==WIDTH-1, write product <= new acc and go to DONE.
  - DONE: done=1 and busy=1 for exactly this one cycle. At the next edge, go unconditionally to IDLE.
- done and busy are decoded from registered state. They are glitch-free and carry no combinational path from start.
- Latency:
  - start high in cycle 0 (sampled at edge E0) gives RUN for WIDTH cycles and done=1 in cycle WIDTH+1.
  - With WIDTH=4: done in cycle 5, and a new start is accepted in cycle 6 at the earliest.
- Throughput: with start held high continuously, one result every WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored. a and b may change freely after acceptance without affecting the result.
- Arithmetic:
  - Unsigned, exact. 2*WIDTH bits always suffice, so no overflow flag.
  - The adder carry-out must be retained as bit 2W-1 of the shifted accumulator; dropping it is a defect.
- product changes only on the RUN->DONE edge. It holds its value across IDLE and through the next RUN.
- rst mid-operation (any state): at that edge, return to IDLE with all registers and outputs zeroed. No done pulse; the partial result is discarded.
- rst and start asserted together: rst wins, start is ignored.
- Operand zero on either side still takes the full WIDTH iterations; there is no early termination.

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH constant;
  - a localparam for the count width, $clog2(WIDTH).
- One natural sub-module: add_rc, a WIDTH-bit combinational ripple-carry adder built from full-adder cells.
  - Ports: a, b, cin, sum, cout.
  - Instantiated once, with cin tied to 0.
  - The multiplier contains no other arithmetic operators.

Test Plan:
- Reset, then a=13, b=11, start for 1 cycle -> busy=1 in cycles 1-5; done=1 in cycle 5 only; product=143 (0x8F) from cycle 5 onward.
- a=15, b=15 -> product=225 (0xE1). Exercises the carry-out retained on every iteration.
- a=0, b=9 then a=9, b=0 -> product=0 both times; each still takes 4 RUN cycles.
- Start accepted with a=6, b=7. Then pulse start with a=2, b=2 in cycle 2 and change a/b during RUN -> product=42; no second operation starts; busy falls in cycle 6.
- rst asserted in cycle 3 of a run (a=12, b=5) -> next cycle busy=0, done=0, product=0; no done pulse. A following start with a=3, b=5 yields 15.
- start held high for 4 back-to-back operations, then an exhaustive sweep of all 256 operand pairs -> done every 6 cycles; each product matches a*b against a reference model.
